// File: rtl/echo_indication_arbiter.sv
// ---------------------------------------------------------------------------
// echo_indication_arbiter
//
// Shares a single outgoing echo indication channel among NREQ requester
// rules. At most one requester is granted per cycle; the granted payload is
// captured in a one-entry output buffer and offered downstream with a
// __RDY/__ENA handshake.
//
// Configuration macro:
//   ECHO_ARB_RR_EN  defined   -> round-robin arbitration with a pointer that
//                                 moves to the last accepted requester.
//                   undefined -> fixed priority, lowest req_want index wins;
//                                 no pointer register is built.
//
// Handshakes (both sides):
//   Upstream:   req_echo__RDY[i] is the grant. req_echo__ENA[i] may only be
//               raised while req_echo__RDY[i] is high; the value is taken on
//               that clock edge. An __ENA without __RDY is ignored apart from
//               setting the sticky err_proto flag.
//   Downstream: ind_echo__ENA means the buffer holds a value; a transfer
//               happens on every edge where ind_echo__ENA and ind_echo__RDY
//               are both high.
//
// Ports:
//   CLK              clock
//   nRST             synchronous active-low reset
//   req_want         per-requester guard (excluding the grant)
//   req_echo__RDY    one-hot or zero grant, forced low during reset
//   req_echo__ENA    per-requester fire strobe
//   req_echo_v       packed payloads, slice i = [i*WIDTH +: WIDTH]
//   ind_echo__ENA    buffer holds a valid value (this is the buffer state)
//   ind_echo_v       buffered payload
//   ind_echo_src     requester index that produced the buffered payload
//   ind_echo__RDY    downstream accepts this cycle
//   delivered_count  completed downstream transfers, wraps at 2^32
//   err_proto        sticky protocol-violation flag, cleared only by reset
// ---------------------------------------------------------------------------
module echo_indication_arbiter #(
    parameter  int NREQ  = 4,
    parameter  int WIDTH = 32,
    localparam int SRCW  = $clog2(NREQ)
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic [NREQ-1:0]         req_want,
    output logic [NREQ-1:0]         req_echo__RDY,
    input  logic [NREQ-1:0]         req_echo__ENA,
    input  logic [NREQ*WIDTH-1:0]   req_echo_v,
    output logic                    ind_echo__ENA,
    output logic [WIDTH-1:0]        ind_echo_v,
    output logic [SRCW-1:0]         ind_echo_src,
    input  logic                    ind_echo__RDY,
    output logic [31:0]             delivered_count,
    output logic                    err_proto
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t            r_state;
    logic [WIDTH-1:0]  r_data;
    logic [SRCW-1:0]   r_src;
    logic [31:0]       r_delivered_count;
    logic              r_err_proto;
`ifdef ECHO_ARB_RR_EN
    logic [SRCW-1:0]   r_ptr;
`endif

    logic              w_can_accept;
    logic              w_xfer;
    logic              w_found;
    logic [SRCW-1:0]   w_gidx;
    logic [NREQ-1:0]   w_grant;
    logic              w_accept;
    logic              w_illegal;

    // A slot is available when empty, or when the current value leaves this
    // same cycle (no bubble between back-to-back values).
    assign w_xfer       = (r_state == ST_FULL) && ind_echo__RDY;
    assign w_can_accept = (r_state == ST_EMPTY) || ind_echo__RDY;

    // Winner search. Depends only on req_want, the pointer and buffer space,
    // never on __ENA, so requesters can fire combinationally from __RDY.
    always_comb begin
        int idx;
        idx     = 0;
        w_found = 1'b0;
        w_gidx  = '0;
        w_grant = '0;
        if (nRST && w_can_accept) begin
`ifdef ECHO_ARB_RR_EN
            // Search starts one past the last winner and wraps around.
            for (int k = 1; k <= NREQ; k++) begin
                idx = (int'(r_ptr) + k) % NREQ;
                if (!w_found && req_want[idx]) begin
                    w_found = 1'b1;
                    w_gidx  = SRCW'(idx);
                end
            end
`else
            for (int k = 0; k < NREQ; k++) begin
                if (!w_found && req_want[k]) begin
                    w_found = 1'b1;
                    w_gidx  = SRCW'(k);
                end
            end
`endif
            if (w_found) begin
                w_grant[w_gidx] = 1'b1;
            end
        end
    end

    assign req_echo__RDY = w_grant;
    assign w_accept      = w_found && req_echo__ENA[w_gidx];
    assign w_illegal     = |(req_echo__ENA & ~w_grant);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            r_state           <= ST_EMPTY;
            r_data            <= '0;
            r_src             <= '0;
            r_delivered_count <= '0;
            r_err_proto       <= 1'b0;
`ifdef ECHO_ARB_RR_EN
            r_ptr             <= SRCW'(NREQ - 1);
`endif
        end else begin
            // Accept has priority over drain: a simultaneous transfer and
            // accept leaves the buffer FULL holding the new value.
            if (w_accept) begin
                r_state <= ST_FULL;
                r_data  <= req_echo_v[int'(w_gidx)*WIDTH +: WIDTH];
                r_src   <= w_gidx;
`ifdef ECHO_ARB_RR_EN
                r_ptr   <= w_gidx;
`endif
            end else if (w_xfer) begin
                r_state <= ST_EMPTY;
            end

            if (w_xfer) begin
                r_delivered_count <= r_delivered_count + 32'd1;
            end

            if (w_illegal) begin
                r_err_proto <= 1'b1;
            end
        end
    end

    assign ind_echo__ENA   = (r_state == ST_FULL);
    assign ind_echo_v      = r_data;
    assign ind_echo_src    = r_src;
    assign delivered_count = r_delivered_count;
    assign err_proto       = r_err_proto;

endmodule

// File: tb/tb_echo_indication_arbiter.sv
module tb_echo_indication_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 32;
  localparam int SRCW  = $clog2(NREQ);

  logic                  CLK;
  logic                  nRST;
  logic [NREQ-1:0]       req_want;
  logic [NREQ-1:0]       req_echo__RDY;
  logic [NREQ-1:0]       req_echo__ENA;
  logic [NREQ*WIDTH-1:0] req_echo_v;
  logic                  ind_echo__ENA;
  logic [WIDTH-1:0]      ind_echo_v;
  logic [SRCW-1:0]       ind_echo_src;
  logic                  ind_echo__RDY;
  logic [31:0]           delivered_count;
  logic                  err_proto;

  int checks;
  int errors;

  echo_indication_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .req_want        (req_want),
    .req_echo__RDY   (req_echo__RDY),
    .req_echo__ENA   (req_echo__ENA),
    .req_echo_v      (req_echo_v),
    .ind_echo__ENA   (ind_echo__ENA),
    .ind_echo_v      (ind_echo_v),
    .ind_echo_src    (ind_echo_src),
    .ind_echo__RDY   (ind_echo__RDY),
    .delivered_count (delivered_count),
    .err_proto       (err_proto)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // driver tasks
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_payload(input int idx, input logic [WIDTH-1:0] val);
    req_echo_v[idx*WIDTH +: WIDTH] = val;
  endtask

  task automatic apply_reset();
    nRST          = 1'b0;
    req_want      = '0;
    req_echo__ENA = '0;
    req_echo_v    = '0;
    ind_echo__RDY = 1'b0;
    step();
    step();
    nRST = 1'b1;
  endtask

  // scenarios
  task automatic test_reset();
    nRST          = 1'b0;
    req_want      = 4'b1111;
    req_echo__ENA = '0;
    req_echo_v    = '0;
    ind_echo__RDY = 1'b1;
    step();
    step();
    checks++;
    if (req_echo__RDY !== 4'b0000) begin
      errors++;
      $display("FAIL reset_rdy: got %b expected 0000", req_echo__RDY);
    end
    checks++;
    if ({ind_echo__ENA, ind_echo_v, ind_echo_src} !== '0) begin
      errors++;
      $display("FAIL reset_ind: ena=%b v=%0d src=%0d expected all 0", ind_echo__ENA, ind_echo_v, ind_echo_src);
    end
    checks++;
    if (delivered_count !== 32'd0 || err_proto !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt_err: count=%0d err=%b expected 0/0", delivered_count, err_proto);
    end
    req_want = '0;
    nRST     = 1'b1;
  endtask

  task automatic test_single();
    apply_reset();
    req_want      = 4'b0001;
    ind_echo__RDY = 1'b1;
    set_payload(0, 32'd22);
    #1;
    checks++;
    if (req_echo__RDY !== 4'b0001) begin
      errors++;
      $display("FAIL single_grant: got %b expected 0001", req_echo__RDY);
    end
    req_echo__ENA = 4'b0001;
    step();
    req_echo__ENA = '0;
    req_want      = '0;
    checks++;
    if (ind_echo__ENA !== 1'b1 || ind_echo_v !== 32'd22 || ind_echo_src !== 2'd0) begin
      errors++;
      $display("FAIL single_out: ena=%b v=%0d src=%0d expected 1/22/0", ind_echo__ENA, ind_echo_v, ind_echo_src);
    end
    step();
    checks++;
    if (ind_echo__ENA !== 1'b0 || delivered_count !== 32'd1) begin
      errors++;
      $display("FAIL single_drain: ena=%b count=%0d expected 0/1", ind_echo__ENA, delivered_count);
    end
  endtask

  task automatic test_fairness();
    logic [SRCW-1:0] exp_src;
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_payload(i, 32'(100 + i));
    req_want      = 4'b1111;
    ind_echo__RDY = 1'b1;
    for (int n = 0; n < 8; n++) begin
      #1;
      req_echo__ENA = req_echo__RDY;
      step();
      req_echo__ENA = '0;
`ifdef ECHO_ARB_RR_EN
      exp_src = SRCW'(n % NREQ);
`else
      exp_src = '0;
`endif
      checks++;
      if (ind_echo__ENA !== 1'b1 || ind_echo_src !== exp_src || ind_echo_v !== 32'(100 + int'(exp_src))) begin
        errors++;
        $display("FAIL fair_%0d: ena=%b src=%0d v=%0d expected 1/%0d/%0d", n, ind_echo__ENA, ind_echo_src, ind_echo_v, exp_src, 100 + int'(exp_src));
      end
    end
    req_want = '0;
    step();
    checks++;
    if (delivered_count !== 32'd8 || ind_echo__ENA !== 1'b0) begin
      errors++;
      $display("FAIL fair_count: count=%0d ena=%b expected 8/0", delivered_count, ind_echo__ENA);
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    ind_echo__RDY = 1'b0;
    req_want      = 4'b0010;
    set_payload(1, 32'd7);
    #1;
    checks++;
    if (req_echo__RDY !== 4'b0010) begin
      errors++;
      $display("FAIL bp_fill_grant: got %b expected 0010", req_echo__RDY);
    end
    req_echo__ENA = req_echo__RDY;
    step();
    req_echo__ENA = '0;
    req_want      = 4'b0011;
    set_payload(0, 32'd9);
    set_payload(1, 32'd8);
    for (int n = 0; n < 5; n++) begin
      #1;
      checks++;
      if (req_echo__RDY !== 4'b0000 || ind_echo__ENA !== 1'b1 || ind_echo_v !== 32'd7 || ind_echo_src !== 2'd1) begin
        errors++;
        $display("FAIL bp_hold_%0d: rdy=%b ena=%b v=%0d src=%0d expected 0000/1/7/1", n, req_echo__RDY, ind_echo__ENA, ind_echo_v, ind_echo_src);
      end
      req_echo__ENA = req_echo__RDY;
      step();
      req_echo__ENA = '0;
    end
    ind_echo__RDY = 1'b1;
    #1;
    checks++;
    if (req_echo__RDY !== 4'b0001) begin
      errors++;
      $display("FAIL bp_release_grant: got %b expected 0001", req_echo__RDY);
    end
    req_echo__ENA = req_echo__RDY;
    step();
    req_echo__ENA = '0;
    req_want      = '0;
    checks++;
    if (ind_echo__ENA !== 1'b1 || ind_echo_v !== 32'd9 || ind_echo_src !== 2'd0 || delivered_count !== 32'd1) begin
      errors++;
      $display("FAIL bp_no_bubble: ena=%b v=%0d src=%0d count=%0d expected 1/9/0/1", ind_echo__ENA, ind_echo_v, ind_echo_src, delivered_count);
    end
    step();
    checks++;
    if (ind_echo__ENA !== 1'b0 || delivered_count !== 32'd2) begin
      errors++;
      $display("FAIL bp_drain: ena=%b count=%0d expected 0/2", ind_echo__ENA, delivered_count);
    end
  endtask

  task automatic test_grant_not_taken();
    logic [NREQ-1:0] exp_rdy;
    apply_reset();
    ind_echo__RDY = 1'b1;
    req_want      = 4'b0010;
    set_payload(1, 32'd11);
    set_payload(2, 32'd55);
    #1;
    req_echo__ENA = 4'b0010;
    step();
    req_echo__ENA = '0;
    req_want      = 4'b0100;
    for (int n = 0; n < 3; n++) begin
      #1;
      checks++;
      if (req_echo__RDY !== 4'b0100) begin
        errors++;
        $display("FAIL gnt_regrant_%0d: got %b expected 0100", n, req_echo__RDY);
      end
      step();
      checks++;
      if (ind_echo__ENA !== 1'b0 || delivered_count !== 32'd1) begin
        errors++;
        $display("FAIL gnt_noload_%0d: ena=%b count=%0d expected 0/1", n, ind_echo__ENA, delivered_count);
      end
    end
    // Pointer must still sit on requester 1, so requester 2 is next in RR.
    req_want = 4'b1111;
`ifdef ECHO_ARB_RR_EN
    exp_rdy = 4'b0100;
`else
    exp_rdy = 4'b0001;
`endif
    #1;
    checks++;
    if (req_echo__RDY !== exp_rdy) begin
      errors++;
      $display("FAIL gnt_ptr_kept: got %b expected %b", req_echo__RDY, exp_rdy);
    end
    req_want = '0;
    step();
  endtask

  task automatic test_proto_error();
    apply_reset();
    ind_echo__RDY = 1'b1;
    req_want      = 4'b0001;
    set_payload(2, 32'd33);
    #1;
    checks++;
    if (req_echo__RDY !== 4'b0001 || err_proto !== 1'b0) begin
      errors++;
      $display("FAIL proto_pre: rdy=%b err=%b expected 0001/0", req_echo__RDY, err_proto);
    end
    req_echo__ENA = 4'b0100;
    step();
    req_echo__ENA = '0;
    req_want      = '0;
    checks++;
    if (err_proto !== 1'b1 || ind_echo__ENA !== 1'b0) begin
      errors++;
      $display("FAIL proto_set: err=%b ena=%b expected 1/0", err_proto, ind_echo__ENA);
    end
    step();
    step();
    checks++;
    if (err_proto !== 1'b1) begin
      errors++;
      $display("FAIL proto_sticky: err=%b expected 1", err_proto);
    end
    apply_reset();
    checks++;
    if (err_proto !== 1'b0) begin
      errors++;
      $display("FAIL proto_clear: err=%b expected 0", err_proto);
    end
  endtask

  task automatic test_counter_wrap();
    apply_reset();
    force dut.r_delivered_count = 32'hFFFF_FFFF;
    #1;
    release dut.r_delivered_count;
    ind_echo__RDY = 1'b1;
    req_want      = 4'b0001;
    set_payload(0, 32'd5);
    #1;
    req_echo__ENA = 4'b0001;
    step();
    req_echo__ENA = '0;
    req_want      = '0;
    checks++;
    if (delivered_count !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_pre: count=%h expected ffffffff", delivered_count);
    end
    step();
    checks++;
    if (delivered_count !== 32'd0) begin
      errors++;
      $display("FAIL wrap: count=%h expected 00000000", delivered_count);
    end
  endtask

  task automatic test_reset_mid();
    apply_reset();
    ind_echo__RDY = 1'b0;
    req_want      = 4'b1000;
    set_payload(3, 32'd77);
    #1;
    req_echo__ENA = 4'b1000;
    step();
    req_echo__ENA = '0;
    checks++;
    if (ind_echo__ENA !== 1'b1 || ind_echo_v !== 32'd77 || ind_echo_src !== 2'd3) begin
      errors++;
      $display("FAIL rmid_fill: ena=%b v=%0d src=%0d expected 1/77/3", ind_echo__ENA, ind_echo_v, ind_echo_src);
    end
    nRST = 1'b0;
    step();
    checks++;
    if ({ind_echo__ENA, ind_echo_v, ind_echo_src} !== '0 || req_echo__RDY !== 4'b0000 || delivered_count !== 32'd0) begin
      errors++;
      $display("FAIL rmid_drop: ena=%b v=%0d src=%0d rdy=%b count=%0d expected all 0", ind_echo__ENA, ind_echo_v, ind_echo_src, req_echo__RDY, delivered_count);
    end
    nRST          = 1'b1;
    req_want      = '0;
    ind_echo__RDY = 1'b1;
    step();
    checks++;
    if (ind_echo__ENA !== 1'b0 || delivered_count !== 32'd0) begin
      errors++;
      $display("FAIL rmid_lost: ena=%b count=%0d expected 0/0", ind_echo__ENA, delivered_count);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_grant_not_taken();
    test_proto_error();
    test_counter_wrap();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
